// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command-side initiator for the 32-bit combinational ALU. It accepts one
//   operand/opcode command at a time, presents it to the ALU for a single
//   EXEC cycle, and captures the result into a held response. A result
//   accumulator lets commands chain. A wrapping counter tracks completed
//   responses.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_opcode, cmd_a, cmd_b   command opcode and operands
//   cmd_use_acc                take operand a from the accumulator
//   alu_a, alu_b, alu_opcode   drive the ALU (opcode is NOOP outside EXEC)
//   alu_result, alu_zero       ALU outputs, sampled at the end of EXEC
//   rsp_valid / rsp_ready      response handshake
//   rsp_result, rsp_zero       response payload
//   rsp_err                    opcode not supported
//   acc_out                    current accumulator
//   rsp_count                  completed responses (wraps)
//   busy                       high in EXEC or RESP
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc_out,
  output logic [CNTW-1:0]  rsp_count,
  output logic             busy
);

  localparam logic [OPW-1:0] OP_NOOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_RESET = OPW'(1);
  localparam logic [OPW-1:0] OP_OR    = OPW'(3);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(6);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(8);
  localparam logic [OPW-1:0] OP_EQ    = OPW'(12);
  localparam logic [OPW-1:0] OP_GT    = OPW'(13);
  localparam logic [OPW-1:0] OP_LT    = OPW'(14);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OPW-1:0]   alu_opcode_q;
  logic [OPW-1:0]   op_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNTW-1:0]  rsp_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      acc_q        <= '0;
      rsp_count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            // alu_a/alu_b double as the latched operands and hold afterwards.
            alu_a_q      <= cmd_use_acc ? acc_q : cmd_a;
            alu_b_q      <= cmd_b;
            alu_opcode_q <= cmd_opcode;
            op_q         <= cmd_opcode;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_EXEC;
          end
        end

        S_EXEC: begin
          alu_opcode_q <= OP_NOOP;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
          case (op_q)
            OP_OR, OP_AND, OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_LT: begin
              rsp_result_q <= alu_result;
              rsp_zero_q   <= alu_zero;
              rsp_err_q    <= 1'b0;
              acc_q        <= alu_result;
            end
            OP_NOOP: begin
              rsp_result_q <= acc_q;
              rsp_zero_q   <= (acc_q == '0);
              rsp_err_q    <= 1'b0;
            end
            OP_RESET: begin
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b1;
              rsp_err_q    <= 1'b0;
              acc_q        <= '0;
            end
            default: begin
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b1;
              rsp_err_q    <= 1'b1;
            end
          endcase
        end

        S_RESP: begin
          // Returning to IDLE (not accepting here) keeps one command in flight.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_count_q <= rsp_count_q + CNTW'(1);
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign acc_out    = acc_q;
  assign rsp_count  = rsp_count_q;

endmodule
